// File: rtl/shot_input_ctrl.sv
// Aim / charge / launch sequencer for one shot: angle adjust, triangle power
// meter, valid/ready handoff of {angle, power}, then wait for flight to end.
module shot_input_ctrl #(
    parameter int ANGLE_MIN  = 15,
    parameter int ANGLE_MAX  = 75,
    parameter int ANGLE_DEF  = 45,
    parameter int ANGLE_STEP = 5,
    parameter int POWER_MAX  = 255,
    parameter int TICK_DIV   = 500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       up_p,
    input  logic       down_p,
    input  logic       shoot_p,
    input  logic       cancel_p,
    input  logic       shot_ready,
    input  logic       shot_done,
    output logic       shot_valid,
    output logic [6:0] angle,
    output logic [7:0] power,
    output logic       charging,
    output logic       busy,
    output logic [1:0] state
);

    localparam int TW = $clog2(TICK_DIV);

    typedef enum logic [1:0] {
        AIM    = 2'd0,
        CHARGE = 2'd1,
        LAUNCH = 2'd2,
        FLIGHT = 2'd3
    } state_t;

    state_t        st;
    logic [TW-1:0] tick;
    logic          dir_down;

    logic [7:0] angle_sum;
    logic [6:0] angle_up;
    logic [6:0] angle_dn;
    logic       tick_last;
    logic [7:0] power_nxt;
    logic       dir_nxt;

    assign state = st;

    // Angle arithmetic is widened to 8 bits so saturation can never wrap.
    always_comb begin
        angle_sum = {1'b0, angle} + 8'(ANGLE_STEP);
        angle_up  = (angle_sum > 8'(ANGLE_MAX)) ? 7'(ANGLE_MAX) : angle_sum[6:0];
        angle_dn  = ({1'b0, angle} < 8'(ANGLE_MIN + ANGLE_STEP)) ? 7'(ANGLE_MIN)
                                                                 : angle - 7'(ANGLE_STEP);
        tick_last = (tick == TW'(TICK_DIV - 1));
    end

    // Triangle sweep: reflect at the peak and at zero so power never leaves range.
    always_comb begin
        power_nxt = power;
        dir_nxt   = dir_down;
        if (!dir_down) begin
            if (power == 8'(POWER_MAX)) begin
                dir_nxt   = 1'b1;
                power_nxt = 8'(POWER_MAX - 1);
            end else begin
                power_nxt = power + 8'd1;
            end
        end else begin
            if (power == 8'd0) begin
                dir_nxt   = 1'b0;
                power_nxt = 8'd1;
            end else begin
                power_nxt = power - 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st         <= AIM;
            angle      <= 7'(ANGLE_DEF);
            power      <= 8'd0;
            shot_valid <= 1'b0;
            tick       <= '0;
            dir_down   <= 1'b0;
            charging   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (st)
                AIM: begin
                    if (shoot_p) begin
                        st       <= CHARGE;
                        power    <= 8'd0;
                        dir_down <= 1'b0;
                        tick     <= '0;
                        charging <= 1'b1;
                    end else if (up_p) begin
                        angle <= angle_up;
                    end else if (down_p) begin
                        angle <= angle_dn;
                    end
                end
                CHARGE: begin
                    if (cancel_p) begin
                        st       <= AIM;
                        power    <= 8'd0;
                        charging <= 1'b0;
                    end else if (shoot_p) begin
                        // Power is left as currently shown; a coinciding step is dropped.
                        st         <= LAUNCH;
                        shot_valid <= 1'b1;
                        charging   <= 1'b0;
                        busy       <= 1'b1;
                    end else if (tick_last) begin
                        tick     <= '0;
                        power    <= power_nxt;
                        dir_down <= dir_nxt;
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                LAUNCH: begin
                    // Acceptance beats a same-edge cancel.
                    if (shot_valid && shot_ready) begin
                        st         <= FLIGHT;
                        shot_valid <= 1'b0;
                    end else if (cancel_p) begin
                        st         <= AIM;
                        shot_valid <= 1'b0;
                        busy       <= 1'b0;
                    end
                end
                FLIGHT: begin
                    if (shot_done) begin
                        st    <= AIM;
                        angle <= 7'(ANGLE_DEF);
                        power <= 8'd0;
                        busy  <= 1'b0;
                    end
                end
                default: st <= AIM;
            endcase
        end
    end

endmodule

// File: tb/tb_shot_input_ctrl.sv
// Scoreboard bench for shot_input_ctrl: directed scenarios then random pulses,
// every cycle's outputs predicted by a behavioural model and checked by a monitor.
module tb_shot_input_ctrl;

    localparam int TD    = 4;
    localparam int PM    = 3;
    localparam int AMIN  = 15;
    localparam int AMAX  = 75;
    localparam int ADEF  = 45;
    localparam int ASTEP = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       up_p = 1'b0, down_p = 1'b0, shoot_p = 1'b0, cancel_p = 1'b0;
    logic       shot_ready = 1'b0, shot_done = 1'b0;
    logic       shot_valid, charging, busy;
    logic [6:0] angle;
    logic [7:0] power;
    logic [1:0] state;

    shot_input_ctrl #(
        .ANGLE_MIN(AMIN), .ANGLE_MAX(AMAX), .ANGLE_DEF(ADEF), .ANGLE_STEP(ASTEP),
        .POWER_MAX(PM), .TICK_DIV(TD)
    ) dut (
        .clk(clk), .rst(rst), .up_p(up_p), .down_p(down_p), .shoot_p(shoot_p),
        .cancel_p(cancel_p), .shot_ready(shot_ready), .shot_done(shot_done),
        .shot_valid(shot_valid), .angle(angle), .power(power), .charging(charging),
        .busy(busy), .state(state)
    );

    always #5 clk = ~clk;

    logic [19:0] exp_q[$];
    int chk_cnt  = 0;
    int pass_cnt = 0;
    int cyc      = 0;

    // Reference model: mode number, angle, held power, valid flag, cycles spent charging.
    int m_mode = 0, m_angle = ADEF, m_power = 0, m_valid = 0, m_k = 0;

    // Power shown after k charge cycles: one step every TD cycles, bouncing 0..PM.
    function automatic int tri_pw(input int k);
        int s;
        s = (k / TD) % (2 * PM);
        return (s <= PM) ? s : 2 * PM - s;
    endfunction

    function automatic logic [19:0] expected();
        int pw;
        pw = (m_mode == 1) ? tri_pw(m_k) : m_power;
        return {2'(m_mode), 1'(m_valid), 7'(m_angle), 8'(pw),
                1'(m_mode == 1), 1'(m_mode >= 2)};
    endfunction

    task automatic step(input logic r, input logic u, input logic d, input logic s,
                        input logic c, input logic rdy, input logic dn);
        @(negedge clk);
        rst = r; up_p = u; down_p = d; shoot_p = s; cancel_p = c;
        shot_ready = rdy; shot_done = dn;
        if (r) begin
            m_mode = 0; m_angle = ADEF; m_power = 0; m_valid = 0;
        end else begin
            case (m_mode)
                0: begin
                    if (s) begin
                        m_mode = 1; m_k = 0;
                    end else if (u) begin
                        m_angle = (m_angle + ASTEP > AMAX) ? AMAX : m_angle + ASTEP;
                    end else if (d) begin
                        m_angle = (m_angle - ASTEP < AMIN) ? AMIN : m_angle - ASTEP;
                    end
                end
                1: begin
                    if (c) begin
                        m_mode = 0; m_power = 0;
                    end else if (s) begin
                        m_mode = 2; m_power = tri_pw(m_k); m_valid = 1;
                    end else begin
                        m_k++;
                    end
                end
                2: begin
                    if (rdy) begin
                        m_mode = 3; m_valid = 0;
                    end else if (c) begin
                        m_mode = 0; m_valid = 0;
                    end
                end
                default: begin
                    if (dn) begin
                        m_mode = 0; m_angle = ADEF; m_power = 0;
                    end
                end
            endcase
        end
        exp_q.push_back(expected());
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, rdy, 0);
    endtask

    // Monitor: outputs are presented every cycle, so each edge consumes one prediction.
    initial begin
        logic [19:0] got, want;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                got  = {state, shot_valid, angle, power, charging, busy};
                chk_cnt++;
                if (got === want) pass_cnt++;
                else $display("FAIL outputs cyc %0d: got st=%0d v=%0b ang=%0d pw=%0d chg=%0b busy=%0b, want st=%0d v=%0b ang=%0d pw=%0d chg=%0b busy=%0b",
                              cyc, got[19:18], got[17], got[16:10], got[9:2], got[1], got[0],
                              want[19:18], want[17], want[16:10], want[9:2], want[1], want[0]);
            end
        end
    end

    initial begin
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        idle(1, 0);

        // Angle saturation at both ends.
        for (int i = 0; i < 7; i++) begin step(0, 1, 0, 0, 0, 0, 0); idle(1, 0); end
        for (int i = 0; i < 13; i++) begin step(0, 0, 1, 0, 0, 0, 0); idle(1, 0); end
        step(0, 1, 0, 0, 0, 0, 0);

        // shoot+up together: charge starts, angle untouched; then a full sweep.
        step(0, 1, 0, 1, 0, 0, 0);
        idle(32, 0);
        for (int i = 0; i < 100 && tri_pw(m_k) != 2; i++) idle(1, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        idle(5, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        idle(1, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        idle(2, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        idle(2, 0);

        // Stray done in AIM, cancel during charge.
        step(0, 1, 0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 0, 0, 0);
        idle(2, 0);
        step(0, 1, 1, 0, 1, 0, 0);
        idle(1, 0);

        // Withdraw from LAUNCH.
        step(0, 0, 0, 1, 0, 0, 0);
        idle(5, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        idle(1, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        idle(1, 0);

        // Cancel coinciding with acceptance.
        step(0, 0, 0, 1, 0, 0, 0);
        idle(3, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 1, 0);
        idle(1, 0);
        step(0, 0, 0, 0, 0, 0, 1);

        // Ready already high when LAUNCH is entered.
        step(0, 0, 0, 1, 0, 1, 0);
        idle(6, 1);
        step(0, 0, 0, 1, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        idle(1, 0);
        step(0, 0, 0, 0, 0, 0, 1);

        // Reset while a shot is offered.
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        idle(1, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        idle(1, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        idle(2, 0);

        // Random pulse traffic.
        for (int i = 0; i < 3000; i++) begin
            logic r, u, d, s, c, rdy, dn;
            r   = ($urandom_range(0, 299) == 0);
            u   = ($urandom_range(0, 9) == 0);
            d   = ($urandom_range(0, 9) == 0);
            s   = ($urandom_range(0, 29) == 0);
            c   = ($urandom_range(0, 39) == 0);
            rdy = ($urandom_range(0, 3) == 0);
            dn  = (m_mode == 3) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 49) == 0);
            step(r, u, d, s, c, rdy, dn);
        end
        idle(1, 0);

        @(posedge clk);
        #3;
        chk_cnt++;
        if (exp_q.size() == 0) pass_cnt++;
        else $display("FAIL drain: got %0d predictions left, want 0", exp_q.size());

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
